// File: rtl/controlador_banco_if.sv
// Bus bundle for controlador_banco: command strobe, LOAD/DUMP streams,
// register-bank ports and status. The controller takes the master view;
// the environment (host, stream endpoints and bank) takes the slave view.
interface controlador_banco_if #(
  parameter int unsigned ANCHO     = 16,
  parameter int unsigned NREG_LOG2 = 3
);
  logic                 cmd_start;
  logic                 cmd_op;
  logic [NREG_LOG2-1:0] cmd_base;
  logic [NREG_LOG2:0]   cmd_count;
  logic [ANCHO-1:0]     in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [ANCHO-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [NREG_LOG2-1:0] w_addr;
  logic                 en_addr;
  logic [ANCHO-1:0]     d;
  logic [NREG_LOG2-1:0] SEL;
  logic [ANCHO-1:0]     R;
  logic                 busy;
  logic                 done;
  logic [ANCHO-1:0]     checksum;

  modport master (
    input  cmd_start, cmd_op, cmd_base, cmd_count,
    input  in_data, in_valid, out_ready, R,
    output in_ready, out_data, out_valid,
    output w_addr, en_addr, d, SEL,
    output busy, done, checksum
  );

  modport slave (
    output cmd_start, cmd_op, cmd_base, cmd_count,
    output in_data, in_valid, out_ready, R,
    input  in_ready, out_data, out_valid,
    input  w_addr, en_addr, d, SEL,
    input  busy, done, checksum
  );
endinterface

// File: rtl/controlador_banco.sv
// controlador_banco: sequencer driving an 8x16 register bank.
// LOAD streams words into consecutive registers, DUMP streams consecutive
// registers out; addresses wrap modulo the register count.
// Optional build macro CONTROLADOR_BANCO_CHECKSUM_EN enables a running
// 16-bit sum of the words moved by the current command; otherwise checksum
// is tied to zero.
module controlador_banco #(
  parameter int unsigned ANCHO     = 16,
  parameter int unsigned NREG_LOG2 = 3
) (
  input  logic                clk,
  input  logic                reset,
  controlador_banco_if.master bus
);

  localparam int unsigned NREG = 1 << NREG_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DUMP,
    S_FIN
  } estado_t;

  estado_t              r_state, w_state_next;
  logic [NREG_LOG2-1:0] r_ptr, w_ptr_next;
  logic [NREG_LOG2:0]   r_rem, w_rem_next;
  logic [ANCHO-1:0]     r_out_data, w_out_data_next;
  logic                 r_out_valid, w_out_valid_next;

  logic [NREG_LOG2:0]   w_count_eff;
  logic                 w_accept;
  logic                 w_in_hs;
  logic                 w_out_hs;
  logic                 w_dump_load;

  // Effective word count: 0 and anything above the bank size mean a full pass
  always_comb begin
    w_count_eff = bus.cmd_count;
    if ((bus.cmd_count == '0) || (bus.cmd_count > (NREG_LOG2+1)'(NREG)))
      w_count_eff = (NREG_LOG2+1)'(NREG);
  end

  // Handshake and bank-port decode from the current state
  always_comb begin
    w_accept    = (r_state == S_IDLE) && bus.cmd_start;
    w_in_hs     = (r_state == S_LOAD) && bus.in_valid;
    w_out_hs    = r_out_valid && bus.out_ready;
    w_dump_load = (r_state == S_DUMP) && (!r_out_valid || bus.out_ready) && (r_rem != '0);
  end

  assign bus.in_ready  = (r_state == S_LOAD);
  assign bus.en_addr   = w_in_hs;
  assign bus.w_addr    = r_ptr;
  assign bus.d         = (r_state == S_LOAD) ? bus.in_data : '0;
  assign bus.SEL       = r_ptr;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_FIN);

  // Next-state, pointer, remaining count and output-register logic
  always_comb begin
    w_state_next     = r_state;
    w_ptr_next       = r_ptr;
    w_rem_next       = r_rem;
    w_out_data_next  = r_out_data;
    w_out_valid_next = r_out_valid;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_ptr_next   = bus.cmd_base;
          w_rem_next   = w_count_eff;
          w_state_next = bus.cmd_op ? S_DUMP : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_in_hs) begin
          w_ptr_next = r_ptr + 1'b1;
          w_rem_next = r_rem - 1'b1;
          if (r_rem == (NREG_LOG2+1)'(1))
            w_state_next = S_FIN;
        end
      end
      S_DUMP: begin
        // A fresh word is loaded whenever the output slot is free or being
        // drained; only once all words are fetched does a drain end the pass.
        if (w_dump_load) begin
          w_out_data_next  = bus.R;
          w_out_valid_next = 1'b1;
          w_ptr_next       = r_ptr + 1'b1;
          w_rem_next       = r_rem - 1'b1;
        end else if (w_out_hs) begin
          w_out_valid_next = 1'b0;
          w_state_next     = S_FIN;
        end
      end
      S_FIN: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_rem       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_rem       <= w_rem_next;
      r_out_data  <= w_out_data_next;
      r_out_valid <= w_out_valid_next;
    end
  end

`ifdef CONTROLADOR_BANCO_CHECKSUM_EN
  logic [ANCHO-1:0] r_checksum;

  // Running sum of transferred words, cleared when a command is accepted
  always_ff @(posedge clk) begin
    if (reset)
      r_checksum <= '0;
    else if (w_accept)
      r_checksum <= '0;
    else if (w_in_hs)
      r_checksum <= r_checksum + bus.in_data;
    else if ((r_state == S_DUMP) && w_out_hs)
      r_checksum <= r_checksum + r_out_data;
  end

  assign bus.checksum = r_checksum;
`else
  assign bus.checksum = '0;
`endif

endmodule

// File: tb/tb_controlador_banco.sv
// Scoreboard bench for controlador_banco with a behavioural bank model.
module tb_controlador_banco;

  localparam int unsigned ANCHO     = 16;
  localparam int unsigned NREG_LOG2 = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bank_clr = 1'b1;

  controlador_banco_if #(.ANCHO(ANCHO), .NREG_LOG2(NREG_LOG2)) bus ();

  controlador_banco #(.ANCHO(ANCHO), .NREG_LOG2(NREG_LOG2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register bank seen by the controller: synchronous write, combinational read
  logic [15:0] bank [8];
  always @(posedge clk) begin
    if (bank_clr) begin
      for (int i = 0; i < 8; i++) bank[i] <= 16'h0;
    end else if (bus.en_addr) begin
      bank[bus.w_addr] <= bus.d;
    end
  end
  assign bus.R = bank[bus.SEL];

  // Reference contents and expectations
  logic [15:0] model [8];
  logic [18:0] exp_wr[$];
  logic [15:0] exp_out[$];
  logic [15:0] exp_done[$];
  logic [15:0] ld_words[$];

  int  vectors = 0;
  int  miscompares = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  function automatic int unsigned eff(input logic [3:0] c);
    return ((c == 4'd0) || (c > 4'd8)) ? 8 : int'(c);
  endfunction

  // Monitor: compares every bank write, output handshake and done pulse
  bit          stall_prev = 1'b0;
  bit          prev_xfer  = 1'b0;
  logic [15:0] hold_data  = 16'h0;
  always @(negedge clk) begin
    logic [18:0] ew;
    logic [15:0] eo;
    if (mon_en) begin
      if (bus.en_addr) begin
        if (exp_wr.size() == 0) fail("bank_write");
        else begin
          ew = exp_wr.pop_front();
          check("bank_write", 32'({bus.w_addr, bus.d}), 32'(ew));
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_out.size() == 0) fail("dump_word");
        else begin
          eo = exp_out.pop_front();
          check("dump_word", 32'(bus.out_data), 32'(eo));
        end
      end
      if (stall_prev)
        check("stall_hold", 32'({bus.out_valid, bus.out_data}), 32'({1'b1, hold_data}));
      if (bus.done) begin
        if (exp_done.size() == 0) fail("done_pulse");
        else begin
          eo = exp_done.pop_front();
          check("checksum_at_done", 32'(bus.checksum), 32'(eo));
          check("done_latency", 32'(prev_xfer), 32'd1);
        end
      end
    end
    prev_xfer  = bus.en_addr || (bus.out_valid && bus.out_ready);
    stall_prev = bus.out_valid && !bus.out_ready;
    hold_data  = bus.out_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int b = 0;
    while (bus.busy && b < 60) begin
      tick();
      b++;
    end
    if (bus.busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Queue expectations for a command, then strobe it for one cycle
  task automatic issue(input bit op, input logic [2:0] base, input logic [3:0] cnt);
    int unsigned n;
    logic [15:0] sum;
    logic [2:0]  a;
    n = eff(cnt);
    sum = 16'h0;
    wait_idle();
    for (int unsigned i = 0; i < n; i++) begin
      a = base + 3'(i);
      if (!op) begin
        exp_wr.push_back({a, ld_words[i]});
        model[a] = ld_words[i];
        sum = sum + ld_words[i];
      end else begin
        exp_out.push_back(model[a]);
        sum = sum + model[a];
      end
    end
`ifndef CONTROLADOR_BANCO_CHECKSUM_EN
    sum = 16'h0;
`endif
    exp_done.push_back(sum);
    bus.cmd_start = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_base  = base;
    bus.cmd_count = cnt;
    tick();
    bus.cmd_start = 1'b0;
    bus.cmd_op    = 1'($urandom);
    bus.cmd_base  = 3'($urandom);
    bus.cmd_count = 4'($urandom);
  endtask

  // Feed LOAD words; vmode 0 = valid held, 1 = toggling, 2 = random
  task automatic run_load(input int unsigned n, input int vmode);
    int unsigned idx = 0;
    int  budget = 0;
    bit  tog = 1'b1;
    bit  hs;
    while (idx < n && budget < 200) begin
      bus.in_data  = ld_words[idx];
      bus.in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? tog : 1'($urandom);
      tog = ~tog;
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      tick();
      if (hs) idx++;
      budget++;
    end
    bus.in_valid = 1'b0;
    if (idx < n) check("load_timeout", 32'(idx), 32'(n));
    wait_idle();
  endtask

  // Drain DUMP words; rmode 0 = ready held, 1 = random, 2 = 3-cycle stall on first word
  task automatic run_dump(input int rmode);
    int b = 0;
    bit seen = 1'b0;
    int stalls = 0;
    while (bus.busy && b < 200) begin
      if (bus.out_valid) seen = 1'b1;
      if (rmode == 0) bus.out_ready = 1'b1;
      else if (rmode == 1) bus.out_ready = 1'($urandom);
      else if (seen && stalls < 3) begin
        bus.out_ready = 1'b0;
        stalls++;
      end else bus.out_ready = !seen ? 1'($urandom) : 1'b1;
      tick();
      b++;
    end
    bus.out_ready = 1'b0;
    if (bus.busy) check("dump_timeout", 32'd1, 32'd0);
  endtask

  task automatic fill_words(input int unsigned n);
    ld_words.delete();
    for (int unsigned i = 0; i < n; i++) ld_words.push_back(16'($urandom));
  endtask

  initial begin
    bus.cmd_start = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_base  = 3'd0;
    bus.cmd_count = 4'd0;
    bus.in_data   = 16'hABCD;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    repeat (3) tick();
    reset    = 1'b0;
    bank_clr = 1'b0;
    tick();

    // Idle after reset, with a word offered that must not be taken
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_en_addr",   32'(bus.en_addr),   32'd0);
    check("rst_w_addr",    32'(bus.w_addr),    32'd0);
    check("rst_d",         32'(bus.d),         32'd0);
    check("rst_SEL",       32'(bus.SEL),       32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_checksum",  32'(bus.checksum),  32'd0);
    bus.in_valid = 1'b0;
    mon_en = 1'b1;

    // Full LOAD 0x1000..0x1007 then full DUMP
    ld_words.delete();
    for (int unsigned i = 0; i < 8; i++) ld_words.push_back(16'h1000 + 16'(i));
    issue(1'b0, 3'd0, 4'd8);
    run_load(8, 0);
    issue(1'b1, 3'd0, 4'd8);
    run_dump(0);

    // Wrap-around LOAD with toggling valid, then full readback (count 0)
    fill_words(4);
    issue(1'b0, 3'd6, 4'd4);
    run_load(4, 1);
    issue(1'b1, 3'd0, 4'd0);
    run_dump(0);

    // Stalled DUMP of three registers
    issue(1'b1, 3'd2, 4'd3);
    run_dump(2);

    // Clamped count, with a command strobe while busy that must be ignored
    fill_words(8);
    issue(1'b0, 3'd3, 4'd12);
    bus.cmd_start = 1'b1;
    bus.cmd_op    = 1'b1;
    bus.cmd_count = 4'd2;
    tick();
    bus.cmd_start = 1'b0;
    run_load(8, 2);
    issue(1'b1, 3'd5, 4'd0);
    run_dump(1);

    // Checksum wrap: 0xFFFF + 0x0002
    ld_words.delete();
    ld_words.push_back(16'hFFFF);
    ld_words.push_back(16'h0002);
    issue(1'b0, 3'd4, 4'd2);
    run_load(2, 0);
    check("checksum_hold", 32'(bus.checksum), 32'(exp_done.size() == 0 ? model[4] + model[5] : 16'h0)
`ifndef CONTROLADOR_BANCO_CHECKSUM_EN
      & 32'h0
`endif
    );

    // Random commands
    for (int k = 0; k < 12; k++) begin
      logic [2:0] b;
      logic [3:0] c;
      b = 3'($urandom);
      c = 4'($urandom);
      if ($urandom_range(1, 0) == 0) begin
        fill_words(eff(c));
        issue(1'b0, b, c);
        run_load(eff(c), int'($urandom_range(2, 0)));
      end else begin
        issue(1'b1, b, c);
        run_dump(int'($urandom_range(1, 0)));
      end
    end

    // Reset in the middle of a DUMP
    wait_idle();
    mon_en = 1'b0;
    issue(1'b1, 3'd0, 4'd8);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b0;
    check("midrst_busy",      32'(bus.busy),      32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_en_addr",   32'(bus.en_addr),   32'd0);
    check("midrst_out_data",  32'(bus.out_data),  32'd0);
    for (int i = 0; i < 3; i++) begin
      check("midrst_no_done", 32'(bus.done), 32'd0);
      tick();
    end
    exp_wr.delete();
    exp_out.delete();
    exp_done.delete();
    mon_en = 1'b1;
    fill_words(1);
    issue(1'b0, 3'd0, 4'd1);
    run_load(1, 0);
    issue(1'b1, 3'd0, 4'd8);
    run_dump(0);

    repeat (3) tick();
    check("wr_queue_empty",   32'(exp_wr.size()),   32'd0);
    check("out_queue_empty",  32'(exp_out.size()),  32'd0);
    check("done_queue_empty", 32'(exp_done.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/controlador_banco.md
Name: controlador_banco

Overview:
- Initiator-side sequencer for the 8x16 register bank: drives the bank's write port (w_addr, en_addr, d) and read select (SEL), and samples its read data (R).
- LOAD command: moves a valid/ready input word stream into consecutive registers.
- DUMP command: reads consecutive registers out onto a valid/ready output stream.
- Sits between a host/stream source and the register bank; the only block that touches bank ports.

Parameters:
- ANCHO, 16, data word width; must match the bank data width.
- NREG_LOG2, 3, register address width (8 registers).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- cmd_start  input  1  one-cycle command strobe; accepted only in IDLE
- cmd_op  input  1  0 = LOAD, 1 = DUMP
- cmd_base  input  3  first register address
- cmd_count  input  4  number of words, 1..8; value 0 means 8, values 9..15 are clamped to 8
- in_data  input  16  LOAD stream data
- in_valid  input  1  LOAD stream valid
- in_ready  output  1  LOAD stream ready
- out_data  output  16  DUMP stream data (registered)
- out_valid  output  1  DUMP stream valid
- out_ready  input  1  DUMP stream ready
- w_addr  output  3  bank write address
- en_addr  output  1  bank write enable
- d  output  16  bank write data
- SEL  output  3  bank read select
- R  input  16  bank read data (combinational from SEL)
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse when a command completes
- checksum  output  16  see Optional Feature

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, en_addr=0, w_addr=0, d=0, SEL=0, busy=0, done=0, checksum=0, state=IDLE, ptr=0, remaining=0.
- States: IDLE, LOAD, DUMP, FIN.
- IDLE:
  - cmd_start=1 latches ptr=cmd_base and remaining=effective count.
  - Goes to LOAD (cmd_op=0) or DUMP (cmd_op=1) on the next edge.
  - cmd_start while busy is ignored (no queueing).
- LOAD:
  - in_ready=1.
  - en_addr = in_valid & in_ready (combinational); w_addr=ptr; d=in_data. The bank writes on the same edge as the handshake.
  - On each handshake: ptr=ptr+1 mod 8, remaining-1.
  - The handshake that brings remaining to 0 also moves to FIN; in_ready=0 from that edge on.
  - No handshake means no write and no state change.
- DUMP:
  - SEL=ptr.
  - Load condition: (!out_valid | out_ready) & remaining!=0. When true, out_data<=R, out_valid<=1, ptr+1 mod 8, remaining-1.
  - When out_valid & !out_ready: out_data and out_valid are held stable and ptr does not advance.
  - When remaining==0 & out_valid & out_ready: out_valid<=0, then go to FIN.
  - Throughput: 1 word/cycle with out_ready held high. First out_valid appears 1 cycle after entering DUMP.
- FIN:
  - done=1 for exactly one cycle, then IDLE.
  - The cycle after FIN is IDLE, so a new cmd_start is accepted there (2-cycle command gap minimum).
- Wrap-around: base=6, count=4 accesses 6,7,0,1.
- en_addr is never asserted outside LOAD; SEL is a don't-care outside DUMP but is driven to ptr.
- Reset mid-command: returns to IDLE the next edge; out_valid and en_addr drop; no done pulse; registers already written keep their contents.
- Simultaneous in_valid with IDLE/FIN: in_ready=0, so the word is not consumed.

Optional Feature:
- Macro: CONTROLADOR_BANCO_CHECKSUM_EN.
- Defined:
  - checksum is a 16-bit modulo-2^16 sum of every word transferred in the current command (LOAD handshakes or DUMP out handshakes).
  - Cleared when a command is accepted.
  - Holds its final value from the done pulse until the next accepted command.
- Undefined: checksum tied to 0; no adder logic.

Test Plan:
- Reset during an active DUMP -> next cycle busy=0, out_valid=0, en_addr=0, no done pulse; a subsequent LOAD base=0 count=1 completes normally.
- LOAD base=0 count=8 with in_data 0x1000..0x1007, in_valid constant -> en_addr high for 8 consecutive cycles with w_addr 0..7; done pulse 1 cycle after the last write. A DUMP base=0 count=8 then returns 0x1000..0x1007 in order.
- LOAD base=6 count=4 with in_valid toggling every other cycle -> writes only on handshake cycles, w_addr sequence 6,7,0,1; remaining registers unchanged.
- DUMP base=2 count=3 with out_ready low for 3 cycles after the first valid -> out_data stays at reg2 value while stalled, then reg3 and reg4; exactly 3 handshakes; done pulses once.
- cmd_count=0 -> 8 words transferred. cmd_count=12 -> 8 words. cmd_start during busy -> ignored, no extra words.
- With CONTROLADOR_BANCO_CHECKSUM_EN defined, LOAD of 0xFFFF, 0x0002 -> checksum=0x0001 at done. Without the macro -> checksum=0 throughout.
